// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: divider state encoding, default
// widths and two's-complement helpers used by the divider and multiplier sign logic.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   localparam int DIV_WIDTH_DEFAULT = 9;

   // Helpers work on a fixed wide vector; callers sign- or zero-extend their
   // operand into it and truncate the result back to their own width.
   localparam int DIV_MAX_WIDTH = 64;

   // Magnitude of a sign-extended two's-complement value. The most-negative
   // value of a narrower operand maps to 2^(W-1), which fits in W unsigned bits.
   function automatic logic [DIV_MAX_WIDTH-1:0] abs_mag(input logic signed [DIV_MAX_WIDTH-1:0] v);
      return v[DIV_MAX_WIDTH-1] ? -v : v;
   endfunction

   // Two's-complement negation; truncating the result gives the W-bit negation.
   function automatic logic [DIV_MAX_WIDTH-1:0] neg2c(input logic [DIV_MAX_WIDTH-1:0] v);
      return -v;
   endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor magnitude, keep the difference if it is not negative.
module restoring_div_step #(
   parameter int WIDTH = 9
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             dividend_bit,
   input  logic [WIDTH-1:0] divisor_mag,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] divisor_ext;

   // Trial subtraction; an unsigned compare stands in for the sign of the difference.
   always_comb begin
      shifted     = {rem_in, dividend_bit};
      divisor_ext = (WIDTH+2)'(divisor_mag);
      q_bit       = (shifted >= divisor_ext);
      rem_out     = q_bit ? (WIDTH+1)'(shifted - divisor_ext) : (WIDTH+1)'(shifted);
   end

endmodule

// File: rtl/signed_seq_divider.sv
// Sequential signed divider: operands are converted to magnitudes, divided by
// WIDTH restoring steps, then the quotient and remainder signs are restored.
module signed_seq_divider
   import arith_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int               CNT_W     = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH:0]   rem_q, rem_d;
   // Holds the dividend magnitude; its MSB feeds each step while quotient
   // bits shift in at the bottom, so it ends up holding the quotient magnitude.
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic             sign_a_q, sign_a_d;
   logic             q_sign_q, q_sign_d;
   logic             ovf_case_q, ovf_case_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             div_by_zero_q, div_by_zero_d;
   logic             overflow_q, overflow_d;

   logic [WIDTH:0]   step_rem;
   logic             step_bit;

   restoring_div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem_in      (rem_q),
      .dividend_bit(dvd_q[WIDTH-1]),
      .divisor_mag (dsr_q),
      .rem_out     (step_rem),
      .q_bit       (step_bit)
   );

   // Next-state and datapath updates for accept, iterate, sign fix-up and hand-off.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      rem_d         = rem_q;
      dvd_d         = dvd_q;
      dsr_d         = dsr_q;
      sign_a_d      = sign_a_q;
      q_sign_d      = q_sign_q;
      ovf_case_d    = ovf_case_q;
      quotient_d    = quotient_q;
      remainder_d   = remainder_q;
      div_by_zero_d = div_by_zero_q;
      overflow_d    = overflow_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_a_d      = dividend[WIDTH-1];
               q_sign_d      = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               dvd_d         = WIDTH'(abs_mag(DIV_MAX_WIDTH'(signed'(dividend))));
               dsr_d         = WIDTH'(abs_mag(DIV_MAX_WIDTH'(signed'(divisor))));
               ovf_case_d    = (dividend == MOST_NEG) && (divisor == '1);
               count_d       = '0;
               rem_d         = '0;
               div_by_zero_d = 1'b0;
               overflow_d    = 1'b0;
               if (divisor == '0) begin
                  quotient_d    = '1;
                  remainder_d   = dividend;
                  div_by_zero_d = 1'b1;
                  state_d       = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d   = step_rem;
            dvd_d   = {dvd_q[WIDTH-2:0], step_bit};
            count_d = count_q + 1'b1;
            if (count_q == LAST_STEP) begin
               state_d = FIX;
            end
         end
         FIX: begin
            quotient_d  = q_sign_q ? WIDTH'(neg2c(DIV_MAX_WIDTH'(dvd_q))) : dvd_q;
            remainder_d = sign_a_q ? WIDTH'(neg2c(DIV_MAX_WIDTH'(rem_q))) : WIDTH'(rem_q);
            overflow_d  = ovf_case_q;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         count_q       <= '0;
         rem_q         <= '0;
         dvd_q         <= '0;
         dsr_q         <= '0;
         sign_a_q      <= 1'b0;
         q_sign_q      <= 1'b0;
         ovf_case_q    <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         rem_q         <= rem_d;
         dvd_q         <= dvd_d;
         dsr_q         <= dsr_d;
         sign_a_q      <= sign_a_d;
         q_sign_q      <= q_sign_d;
         ovf_case_q    <= ovf_case_d;
         quotient_q    <= quotient_d;
         remainder_q   <= remainder_d;
         div_by_zero_q <= div_by_zero_d;
         overflow_q    <= overflow_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = div_by_zero_q;
   assign overflow    = overflow_q;

endmodule
